// File: rtl/fir_pkg.sv
// Shared constants and lane encoding for the 3-unfolded FIR output path.
package fir_pkg;

   localparam int NB = 14;

   typedef enum logic [1:0] {
      LANE0 = 2'd0,
      LANE1 = 2'd1,
      LANE2 = 2'd2
   } lane_e;

endpackage

// File: rtl/fir3_out_serializer_if.sv
// Triplet input port (no back-pressure) and serialized valid/ready output port.
interface fir3_out_serializer_if #(
   parameter int NB = fir_pkg::NB
);

   logic [NB-1:0] din1;
   logic [NB-1:0] din2;
   logic [NB-1:0] din3;
   logic          vin;
   logic [NB-1:0] dout;
   logic          vout;
   logic          rdy;

   modport master (output din1, din2, din3, vin, rdy, input dout, vout);
   modport slave  (input din1, din2, din3, vin, rdy, output dout, vout);

endinterface

// File: rtl/triplet_fifo.sv
// Synchronous show-ahead FIFO; the caller qualifies wr_en/rd_en against full/empty.
module triplet_fifo #(
   parameter int W     = 42,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [W-1:0]               wr_data,
   input  logic                       rd_en,
   output logic [W-1:0]               rd_data,
   output logic [$clog2(DEPTH+1)-1:0] cnt,
   output logic                       full,
   output logic                       empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_en, rd_en})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // NOTE: storage is not reset; cnt_q alone decides what is valid, and a resettable array costs a RAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign cnt     = cnt_q;
   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);

endmodule

// File: rtl/fir3_out_serializer.sv
// Buffers FIR output triplets and re-emits them one sample per transfer, flagging dropped triplets.
module fir3_out_serializer
   import fir_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   fir3_out_serializer_if.slave       bus,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] cnt,
   output logic                       ovf
);

   logic [3*NB-1:0] head;
   logic [NB-1:0]   dout_mux;
   logic            empty;
   logic            xfer;
   logic            pop;
   logic            wr_en;
   lane_e           lane_q, lane_d;
   logic            ovf_q, ovf_d;

   assign bus.vout = !empty;
   assign xfer     = bus.vout & bus.rdy;
   assign pop      = xfer & (lane_q == LANE2);
   // A lane-2 pop frees a slot in the same edge, so a write at full is still accepted.
   assign wr_en    = bus.vin & (!full | pop);

   triplet_fifo #(
      .W     (3*NB),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data ({bus.din1, bus.din2, bus.din3}),
      .rd_en   (pop),
      .rd_data (head),
      .cnt     (cnt),
      .full    (full),
      .empty   (empty)
   );

   always_comb begin
      lane_d = lane_q;
      if (xfer) begin
         case (lane_q)
            LANE0:   lane_d = LANE1;
            LANE1:   lane_d = LANE2;
            default: lane_d = LANE0;
         endcase
      end
      ovf_d = ovf_q | (bus.vin & full & !pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_q <= LANE0;
         ovf_q  <= 1'b0;
      end else begin
         lane_q <= lane_d;
         ovf_q  <= ovf_d;
      end
   end

   // Zero-gate keeps stale FIFO contents off dout while nothing is valid.
   always_comb begin
      dout_mux = '0;
      if (!empty) begin
         case (lane_q)
            LANE0:   dout_mux = head[3*NB-1 -: NB];
            LANE1:   dout_mux = head[2*NB-1 -: NB];
            default: dout_mux = head[NB-1:0];
         endcase
      end
   end

   assign bus.dout = dout_mux;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_fir3_out_serializer.sv
// Directed bench for fir3_out_serializer with an in-order sample scoreboard.
module tb_fir3_out_serializer;
   import fir_pkg::*;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst;
   logic          full;
   logic [CW-1:0] cnt;
   logic          ovf;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [NB-1:0] sb [$];

   fir3_out_serializer_if bus ();

   fir3_out_serializer #(.DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .full (full),
      .cnt  (cnt),
      .ovf  (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: score any transfer at the negedge, then land 1ns after the next posedge.
   task automatic tick();
      @(negedge clk);
      if (!rst && bus.vout === 1'b1 && bus.rdy === 1'b1) begin
         n_checks++;
         assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_sample: observed 0x%0h expected no output", bus.dout);
         end
         if (sb.size() != 0) check("dout_seq", 32'(bus.dout), 32'(sb.pop_front()));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [NB-1:0] a, input logic [NB-1:0] b,
                       input logic [NB-1:0] c, input bit accepted);
      bus.din1 = a;
      bus.din2 = b;
      bus.din3 = c;
      bus.vin  = 1'b1;
      if (accepted) begin
         sb.push_back(a);
         sb.push_back(b);
         sb.push_back(c);
      end
      tick();
      bus.vin  = 1'b0;
      bus.din1 = '0;
      bus.din2 = '0;
      bus.din3 = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst      = 1'b1;
      bus.vin  = 1'b0;
      bus.rdy  = 1'b0;
      bus.din1 = '0;
      bus.din2 = '0;
      bus.din3 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_vout", 32'(bus.vout), 32'd0);
      check("rst_dout", 32'(bus.dout), 32'd0);
      check("rst_cnt",  32'(cnt),      32'd0);
      check("rst_full", 32'(full),     32'd0);
      check("rst_ovf",  32'(ovf),      32'd0);
      rst = 1'b0;
      tick();

      // Single triplet with extreme-ish values, continuous ready.
      bus.rdy = 1'b1;
      send(14'h0001, 14'h1FFF, 14'h2000, 1'b1);
      check("t2_vout_first", 32'(bus.vout), 32'd1);
      check("t2_dout_first", 32'(bus.dout), 32'h0001);
      repeat (3) tick();
      check("t2_vout_end", 32'(bus.vout), 32'd0);
      check("t2_dout_end", 32'(bus.dout), 32'd0);

      // Back-pressure at lane 1 must hold the sample.
      send(14'h0001, 14'h1FFF, 14'h2000, 1'b1);
      tick();
      bus.rdy = 1'b0;
      repeat (2) begin
         tick();
         check("t3_hold_vout", 32'(bus.vout), 32'd1);
         check("t3_hold_dout", 32'(bus.dout), 32'h1FFF);
      end
      bus.rdy = 1'b1;
      repeat (2) tick();
      check("t3_vout_end", 32'(bus.vout), 32'd0);

      // Sustained rate: one triplet every third cycle, output must be gap-free.
      for (int k = 0; k < 30; k++) begin
         send(NB'(3*k), NB'(3*k+1), NB'(3*k+2), 1'b1);
         check("t4_vout", 32'(bus.vout), 32'd1);
         repeat (2) begin
            tick();
            check("t4_vout", 32'(bus.vout), 32'd1);
         end
         check("t4_cnt_le1", 32'(cnt <= CW'(1)), 32'd1);
         check("t4_ovf",     32'(ovf),           32'd0);
      end
      tick();
      check("t4_vout_end", 32'(bus.vout), 32'd0);
      check("t4_sb_empty", 32'(sb.size()), 32'd0);

      // Overflow: stalled output, five back-to-back triplets into a depth-4 buffer.
      bus.rdy = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         send(NB'(16'h100*i), NB'(16'h100*i + 1), NB'(16'h100*i + 2), i <= 4);
         if (i == 4) begin
            check("t5_full_at4", 32'(full), 32'd1);
            check("t5_cnt_at4",  32'(cnt),  32'd4);
            check("t5_ovf_at4",  32'(ovf),  32'd0);
         end
      end
      check("t5_ovf_set", 32'(ovf),  32'd1);
      check("t5_cnt_at5", 32'(cnt),  32'd4);
      bus.rdy = 1'b1;
      repeat (12) tick();
      check("t5_vout_end", 32'(bus.vout), 32'd0);
      check("t5_sb_empty", 32'(sb.size()), 32'd0);
      check("t5_ovf_sticky", 32'(ovf), 32'd1);

      // Asynchronous reset mid-stream with cnt=2, lane=1.
      send(14'h0A01, 14'h0A02, 14'h0A03, 1'b1);
      send(14'h0B01, 14'h0B02, 14'h0B03, 1'b1);
      check("t1_cnt_pre",  32'(cnt),      32'd2);
      check("t1_dout_pre", 32'(bus.dout), 32'h0A02);
      #2;
      rst = 1'b1;
      #1;
      check("t1_rst_vout", 32'(bus.vout), 32'd0);
      check("t1_rst_dout", 32'(bus.dout), 32'd0);
      check("t1_rst_cnt",  32'(cnt),      32'd0);
      check("t1_rst_full", 32'(full),     32'd0);
      check("t1_rst_ovf",  32'(ovf),      32'd0);
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) tick();
      check("t1_no_stale", 32'(bus.vout), 32'd0);

      // Full buffer, lane-2 pop coincident with a write: not an overflow.
      bus.rdy = 1'b0;
      for (int i = 1; i <= 4; i++)
         send(NB'(16'h300 + 16'h10*i), NB'(16'h301 + 16'h10*i), NB'(16'h302 + 16'h10*i), 1'b1);
      check("t6_full", 32'(full), 32'd1);
      bus.rdy = 1'b1;
      repeat (2) tick();
      send(14'h3F00, 14'h3F01, 14'h3F02, 1'b1);
      check("t6_cnt_kept",  32'(cnt),  32'd4);
      check("t6_full_kept", 32'(full), 32'd1);
      check("t6_no_ovf",    32'(ovf),  32'd0);
      repeat (12) tick();
      check("t6_vout_end", 32'(bus.vout), 32'd0);
      check("t6_sb_empty", 32'(sb.size()), 32'd0);
      check("t6_ovf_end",  32'(ovf), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
